// File: rtl/layer_act_buffer.sv
// layer_act_buffer: gathers a serial float activation stream into NUM_IN parallel slots feeding a node bank.
// Latency: node_out sampled SETTLE edges after the last accepted word; out_valid visible SETTLE+1 cycles after it.
// Backpressure: in_ready low outside FILL; result held in HOLD until out_ready, refill starts the cycle after.
module layer_act_buffer #(
  parameter int NUM_IN    = 30,
  parameter int NUM_NODES = 1,
  parameter int SETTLE    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_data,
  input  logic                    in_last,
  output logic [NUM_IN*32-1:0]    act_bus,
  input  logic [NUM_NODES*32-1:0] node_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_NODES*32-1:0] out_data,
  output logic                    busy,
  output logic                    err_len
);

  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_IN - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

  typedef enum logic [1:0] {ST_FILL, ST_SETTLE, ST_HOLD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] wr_idx;
  logic [CW-1:0] cnt;
  logic [31:0]   slot [NUM_IN];
  logic          xfer;
  logic          vec_end;
  logic          short_vec;
  logic          long_vec;
  logic          sample_node;

  assign in_ready    = (state == ST_FILL) & ~rst;
  assign busy        = (state != ST_FILL);
  assign xfer        = in_valid & in_ready;
  // a vector closes on in_last or when the last slot is written, whichever comes first
  assign vec_end     = xfer & (in_last | (wr_idx == LAST_IDX));
  assign short_vec   = in_last & (wr_idx != LAST_IDX);
  assign long_vec    = ~in_last & (wr_idx == LAST_IDX);
  assign sample_node = (state == ST_SETTLE) & (cnt == '0);

  for (genvar g = 0; g < NUM_IN; g++) begin : g_bus
    assign act_bus[32*g +: 32] = slot[g];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FILL;
    else     state <= state_nxt;
  end

  // Next-state: FILL -> SETTLE on vector end, SETTLE -> HOLD when counter expires, HOLD -> FILL on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL:   if (vec_end)     state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == '0)   state_nxt = ST_HOLD;
      ST_HOLD:   if (out_ready)   state_nxt = ST_FILL;
      default:                    state_nxt = ST_FILL;
    endcase
  end

  // Write pointer, settle down-counter and sticky length-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx  <= '0;
      cnt     <= '0;
      err_len <= 1'b0;
    end else if (vec_end) begin
      wr_idx <= '0;
      cnt    <= CNT_INIT;
      if (short_vec | long_vec) err_len <= 1'b1;
    end else if (xfer) begin
      wr_idx <= wr_idx + 1'b1;
    end else if ((state == ST_SETTLE) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Activation slots: write the addressed slot; an early in_last zero-fills every slot above it.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_IN; k++) begin
      if (rst) begin
        slot[k] <= '0;
      end else if (xfer) begin
        if (wr_idx == IW'(k))                 slot[k] <= in_data;
        else if (in_last && (wr_idx < IW'(k))) slot[k] <= '0;
      end
    end
  end

  // Result register: capture node_out on the last settle cycle, release on the downstream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (sample_node) begin
      out_valid <= 1'b1;
      out_data  <= node_out;
    end else if ((state == ST_HOLD) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
